// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP operand sequencer: FSM state encoding
// and the byte/display widths used by the datapath.
package fp_seq_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        SHOW   = 2'd3
    } seq_state_t;

    localparam int BYTE_W = 8;
    localparam int DISP_W = 16;

    // Counter width that stays at least one bit even when only one value is needed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_operand_sequencer_if.sv
// Operand/handshake bundle between the sequencer (master) and the FP multiplier (slave).
interface fp_operand_sequencer_if #(
    parameter int FP_WIDTH = 32
) ();
    import fp_seq_pkg::*;

    logic [FP_WIDTH-1:0] op_a;
    logic [FP_WIDTH-1:0] op_b;
    logic                start;
    logic                mul_done;
    logic [FP_WIDTH-1:0] mul_result;

    modport master (
        output op_a, op_b, start,
        input  mul_done, mul_result
    );

    modport slave (
        input  op_a, op_b, start,
        output mul_done, mul_result
    );

endinterface

// File: rtl/press_detect.sv
// ENTER button conditioning: two-flop synchroniser followed by a falling-edge detector.
module press_detect (
    input  logic clk,
    input  logic nreset,
    input  logic nenter,
    output logic press
);
    // [0],[1] synchronise the raw button, [2] holds the previous synchronised level.
    logic [2:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], nenter};
        end
    end

    assign press = sync_reg[2] & ~sync_reg[1];

endmodule

// File: rtl/fp_operand_sequencer.sv
// Byte-wise operand entry, multiplier start/timeout control and paged result display
// for the FP multiplier front panel.
module fp_operand_sequencer
    import fp_seq_pkg::*;
#(
    parameter int FP_WIDTH = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  nenter,
    input  logic [BYTE_W-1:0]     inputdata,
    fp_operand_sequencer_if.master mul,
    output logic                  busy,
    output logic                  error,
    output seq_state_t            phase,
    output logic [DISP_W-1:0]     disp_word
);
    localparam int NB   = FP_WIDTH / BYTE_W;
    localparam int NP   = FP_WIDTH / DISP_W;
    localparam int BC_W = cnt_width(NB);
    localparam int PG_W = cnt_width(NP);
    localparam int TO_W = cnt_width(TIMEOUT);

    logic press;

    seq_state_t          state_reg;
    logic [FP_WIDTH-1:0] op_a_reg;
    logic [FP_WIDTH-1:0] op_b_reg;
    logic [FP_WIDTH-1:0] result_reg;
    logic [BC_W-1:0]     byte_cnt_reg;
    logic [PG_W-1:0]     page_reg;
    logic [TO_W-1:0]     to_cnt_reg;
    logic                start_reg;
    logic                busy_reg;
    logic                error_reg;
    logic [DISP_W-1:0]   disp_reg;

    press_detect u_press_detect (
        .clk    (clk),
        .nreset (nreset),
        .nenter (nenter),
        .press  (press)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg    <= LOAD_A;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            result_reg   <= '0;
            byte_cnt_reg <= '0;
            page_reg     <= '0;
            to_cnt_reg   <= '0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b0;
            disp_reg     <= '0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                LOAD_A: begin
                    if (press) begin
                        op_a_reg <= {op_a_reg[FP_WIDTH-BYTE_W-1:0], inputdata};
                        if (byte_cnt_reg == BC_W'(NB - 1)) begin
                            byte_cnt_reg <= '0;
                            state_reg    <= LOAD_B;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        op_b_reg <= {op_b_reg[FP_WIDTH-BYTE_W-1:0], inputdata};
                        if (byte_cnt_reg == BC_W'(NB - 1)) begin
                            byte_cnt_reg <= '0;
                            to_cnt_reg   <= '0;
                            start_reg    <= 1'b1;
                            busy_reg     <= 1'b1;
                            state_reg    <= RUN;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Done is checked first so a done on the last allowed cycle still wins.
                    if (mul.mul_done) begin
                        result_reg <= mul.mul_result;
                        busy_reg   <= 1'b0;
                        page_reg   <= PG_W'(NP - 1);
                        state_reg  <= SHOW;
                    end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        result_reg <= '0;
                        error_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                        page_reg   <= PG_W'(NP - 1);
                        state_reg  <= SHOW;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                SHOW: begin
                    if (press) begin
                        page_reg <= (page_reg == '0) ? PG_W'(NP - 1) : page_reg - 1'b1;
                    end
                end
                default: state_reg <= LOAD_A;
            endcase

            // Display follows the state one cycle late.
            case (state_reg)
                LOAD_A:  disp_reg <= op_a_reg[DISP_W-1:0];
                LOAD_B:  disp_reg <= op_b_reg[DISP_W-1:0];
                SHOW:    disp_reg <= result_reg[DISP_W*page_reg +: DISP_W];
                default: disp_reg <= '0;
            endcase
        end
    end

    assign mul.op_a  = op_a_reg;
    assign mul.op_b  = op_b_reg;
    assign mul.start = start_reg;
    assign busy      = busy_reg;
    assign error     = error_reg;
    assign phase     = state_reg;
    assign disp_word = disp_reg;

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// Directed-plus-random bench for fp_operand_sequencer: a 32-bit and a 16-bit instance
// share the button/reset/done stimulus and are checked against expected values built here.
module tb_fp_operand_sequencer;
    import fp_seq_pkg::*;

    logic        clk = 1'b0;
    logic        nreset;
    logic        nenter;
    logic        mul_done;
    logic [7:0]  inputdata;
    logic [31:0] res32;
    logic [15:0] res16;

    logic        busy32, error32, busy16, error16;
    seq_state_t  phase32, phase16;
    logic [15:0] disp32, disp16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_operand_sequencer_if #(.FP_WIDTH(32)) m32 ();
    fp_operand_sequencer_if #(.FP_WIDTH(16)) m16 ();

    assign m32.mul_done   = mul_done;
    assign m32.mul_result = res32;
    assign m16.mul_done   = mul_done;
    assign m16.mul_result = res16;

    fp_operand_sequencer #(.FP_WIDTH(32), .TIMEOUT(16)) dut32 (
        .clk       (clk),
        .nreset    (nreset),
        .nenter    (nenter),
        .inputdata (inputdata),
        .mul       (m32),
        .busy      (busy32),
        .error     (error32),
        .phase     (phase32),
        .disp_word (disp32)
    );

    fp_operand_sequencer #(.FP_WIDTH(16), .TIMEOUT(16)) dut16 (
        .clk       (clk),
        .nreset    (nreset),
        .nenter    (nenter),
        .inputdata (inputdata),
        .mul       (m16),
        .busy      (busy16),
        .error     (error16),
        .phase     (phase16),
        .disp_word (disp16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset   = 1'b0;
        nenter   = 1'b1;
        mul_done = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Idle gap, then a press held until the cycle after it has taken effect.
    task automatic press(input logic [7:0] b);
        inputdata = b;
        nenter    = 1'b1;
        repeat (3) @(negedge clk);
        nenter = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nenter = 1'b1;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
    endtask

    // Loads both 32-bit operands MSB byte first; returns in the first RUN cycle.
    task automatic load32(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--) begin
            press(a[8*i +: 8]);
            check("op_a_shift", m32.op_a, a >> (8 * i));
        end
        check("phase_load_b", phase32, LOAD_B);
        for (int i = 3; i >= 0; i--) begin
            press(b[8*i +: 8]);
            check("op_b_shift", m32.op_b, b >> (8 * i));
        end
        check("phase_run", phase32, RUN);
        check("start_first", m32.start, 1'b1);
    endtask

    initial begin
        logic [31:0] a, b, r;
        logic [7:0]  byte0;
        int          cyc;

        nreset    = 1'b1;
        nenter    = 1'b1;
        mul_done  = 1'b0;
        inputdata = 8'h00;
        res32     = '0;
        res16     = '0;

        // Reset state
        do_reset();
        check("rst_phase", phase32, LOAD_A);
        check("rst_op_a", m32.op_a, 32'h0);
        check("rst_op_b", m32.op_b, 32'h0);
        check("rst_start", m32.start, 1'b0);
        check("rst_busy", busy32, 1'b0);
        check("rst_error", error32, 1'b0);
        check("rst_disp", disp32, 16'h0);

        // mul_done outside RUN is ignored
        res32 = $urandom;
        pulse_done();
        @(negedge clk);
        check("done_ign_phase", phase32, LOAD_A);
        check("done_ign_busy", busy32, 1'b0);
        check("done_ign_disp", disp32, 16'h0);

        // Held button counts once, then three more bytes complete operand A
        byte0     = 8'($urandom);
        inputdata = byte0;
        nenter    = 1'b0;
        repeat (100) @(negedge clk);
        nenter = 1'b1;
        check("held_op_a", m32.op_a, {24'h0, byte0});
        check("held_phase", phase32, LOAD_A);
        a = {24'h0, byte0};
        for (int i = 0; i < 3; i++) begin
            byte0 = 8'($urandom);
            press(byte0);
            a = (a << 8) | {24'h0, byte0};
        end
        check("held_op_a_full", m32.op_a, a);
        check("held_phase_b", phase32, LOAD_B);

        // Directed 32-bit load, start pulse, done and paging
        do_reset();
        load32(32'h3FC00000, 32'h40000000);
        check("run_busy", busy32, 1'b1);
        @(negedge clk);
        check("start_once", m32.start, 1'b0);
        check("run_busy2", busy32, 1'b1);
        check("run_disp", disp32, 16'h0);
        repeat (3) @(negedge clk);
        res32    = 32'h40400000;
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
        check("show_phase", phase32, SHOW);
        check("show_busy", busy32, 1'b0);
        check("show_error", error32, 1'b0);
        @(negedge clk);
        check("page_hi", disp32, 16'h4040);
        press(8'($urandom));
        @(negedge clk);
        check("page_lo", disp32, 16'h0000);
        press(8'($urandom));
        @(negedge clk);
        check("page_wrap", disp32, 16'h4040);

        // Reset in the middle of loading operand B
        do_reset();
        a = $urandom;
        for (int i = 3; i >= 0; i--) press(a[8*i +: 8]);
        b = $urandom;
        press(b[31:24]);
        press(b[23:16]);
        check("mid_op_b", m32.op_b, {16'h0, b[31:16]});
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        check("mid_rst_phase", phase32, LOAD_A);
        check("mid_rst_op_a", m32.op_a, 32'h0);
        check("mid_rst_op_b", m32.op_b, 32'h0);
        check("mid_rst_disp", disp32, 16'h0);

        // Timeout with random operands
        do_reset();
        a = $urandom;
        b = $urandom;
        load32(a, b);
        cyc = 0;
        while (phase32 != SHOW && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", 64'(cyc), 64'd16);
        check("timeout_error", error32, 1'b1);
        check("timeout_busy", busy32, 1'b0);
        @(negedge clk);
        check("timeout_page1", disp32, 16'h0);
        press(8'($urandom));
        @(negedge clk);
        check("timeout_page0", disp32, 16'h0);

        // Presses in RUN are ignored; random result paging
        do_reset();
        a = $urandom;
        b = $urandom;
        load32(a, b);
        press(8'($urandom));
        check("runpress_phase", phase32, RUN);
        check("runpress_op_a", m32.op_a, a);
        check("runpress_op_b", m32.op_b, b);
        r     = $urandom;
        res32 = r;
        pulse_done();
        check("rand_show", phase32, SHOW);
        check("rand_error", error32, 1'b0);
        @(negedge clk);
        check("rand_page1", disp32, r[31:16]);
        press(8'($urandom));
        @(negedge clk);
        check("rand_page0", disp32, r[15:0]);
        press(8'($urandom));
        @(negedge clk);
        check("rand_wrap", disp32, r[31:16]);

        // Done arriving on the last allowed RUN cycle beats the timeout
        do_reset();
        load32($urandom, $urandom);
        repeat (15) @(negedge clk);
        r        = $urandom;
        res32    = r;
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
        check("race_phase", phase32, SHOW);
        check("race_error", error32, 1'b0);
        @(negedge clk);
        check("race_disp", disp32, r[31:16]);

        // 16-bit instance: two bytes per operand, single display page
        do_reset();
        press(8'h3C);
        press(8'h00);
        check("w16_op_a", m16.op_a, 16'h3C00);
        check("w16_phase_b", phase16, LOAD_B);
        press(8'h40);
        check("w16_phase_b2", phase16, LOAD_B);
        press(8'h00);
        check("w16_op_b", m16.op_b, 16'h4000);
        check("w16_phase_run", phase16, RUN);
        check("w16_start", m16.start, 1'b1);
        res16 = 16'h4000;
        pulse_done();
        check("w16_show", phase16, SHOW);
        @(negedge clk);
        check("w16_disp", disp16, 16'h4000);
        press(8'($urandom));
        @(negedge clk);
        check("w16_disp_press", disp16, 16'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
